aclk_time_counter: RTL and testbench
====================================

Name: aclk_time_counter

Overview:
- Consumer end of the alarm-clock time-base interface.
- Takes the one_minute strobe from the time generator and maintains the current time of day as 24-hour BCD HH:MM.
- Holds a programmable alarm time and raises sound_alarm when the running time reaches it.
- Drives reset_count back to the generator so the sub-minute phase restarts whenever a new time is loaded.

Parameters:
- None. Format is fixed at 24-hour, 4 BCD digits.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- one_minute  input  1  single-cycle advance strobe from the time generator.
- load_time  input  1  load new_time into the current time this cycle.
- load_alarm  input  1  load new_time into the alarm register this cycle.
- new_time  input  16  {hr_ms, hr_ls, min_ms, min_ls}, 4-bit BCD each.
- alarm_en  input  1  alarm enable, level.
- stop_alarm  input  1  clears sound_alarm.
- reset_count  output  1  restart request to the time generator.
- cur_time  output  16  current time, same packing as new_time.
- alarm_time  output  16  stored alarm time, same packing.
- sound_alarm  output  1  alarm active, level.
- load_err  output  1  one-cycle pulse when a load request is rejected.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
- Reset values: cur_time=16'h0000, alarm_time=16'h0000, sound_alarm=0, load_err=0.
- All state is registered on posedge clk.
- Validity check on new_time:
  - Valid when hr_ms<=2, hr_ls<=9, (hr_ms==2 implies hr_ls<=3), min_ms<=5, min_ls<=9.
  - Otherwise invalid.
- load_time with valid data: cur_time<=new_time at the next edge.
- load_alarm with valid data: alarm_time<=new_time at the next edge.
- Invalid load: the targeted register is unchanged and load_err=1 for exactly one cycle.
- load_time and load_alarm together: both registers load the same value; one load_err pulse if invalid.
- reset_count: combinational copy of load_time, asserted regardless of data validity, so the generator restarts the minute in the same cycle.
- Increment: on one_minute=1 with load_time=0, cur_time advances by one minute at the next edge.
  - min_ls 9->0 carries into min_ms.
  - min_ms 5->0 carries into hours.
  - Hours step 09->10 and 19->20.
  - 23:59 wraps to 00:00; no other state is touched on wrap.
- Priority: load_time beats one_minute in the same cycle. The load is taken and the strobe is dropped, not deferred.
- Alarm set: at the edge where an increment produces a value equal to alarm_time, with alarm_en=1, sound_alarm<=1.
  - Loads never set the alarm, including a load_time whose value equals alarm_time.
- Alarm clear: sound_alarm<=0 when stop_alarm=1 or alarm_en=0.
  - Clear beats set in the same cycle.
  - Otherwise sound_alarm holds until cleared; it does not self-clear after the matching minute.
- Changing alarm_time while sound_alarm=1 has no effect on sound_alarm.
- Reset mid-operation: all state returns to reset values immediately; a pending strobe is lost.
- Outputs cur_time and alarm_time are direct register outputs with no extra latency.

Test Plan:
- Reset, then 3 one_minute pulses -> cur_time 16'h0000 -> 16'h0003. sound_alarm=0, load_err=0.
- load_time new_time=16'h0959, then one_minute -> cur_time 16'h1000.
  - Repeat from 16'h1959 -> 16'h2000.
  - Repeat from 16'h2359 -> 16'h0000.
  - reset_count high exactly in each load cycle.
- load_time new_time=16'h2400, then 16'h1260, then 16'h0A00 -> cur_time unchanged each time, load_err one-cycle pulse each time, reset_count still pulses.
- load_alarm 16'h0705, alarm_en=1, load_time 16'h0704, one_minute -> cur_time 16'h0705 and sound_alarm=1 at the same edge.
  - sound_alarm stays high through further minutes.
  - stop_alarm -> sound_alarm=0 next edge.
- Same setup with alarm_en=0 -> no alarm.
  - load_time 16'h0705 directly -> no alarm.
  - stop_alarm asserted in the match cycle -> sound_alarm stays 0.
- load_time 16'h1111 and one_minute in the same cycle -> cur_time 16'h1111, not 16'h1112.
  - Assert reset while sound_alarm=1 -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/aclk_time_counter.sv
// ---------------------------------------------------------------------------
// aclk_time_counter
//
// Keeps the alarm clock's time of day as 24-hour BCD HH:MM. It advances on the
// one_minute strobe from the time generator. It also holds a programmable
// alarm time and raises sound_alarm when an increment reaches that time.
// reset_count goes back to the generator so that the sub-minute phase
// restarts whenever a new time is loaded.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   one_minute   in   single-cycle advance strobe
//   load_time    in   load new_time into the current time
//   load_alarm   in   load new_time into the alarm register
//   new_time     in   {hr_ms, hr_ls, min_ms, min_ls}, 4-bit BCD each
//   alarm_en     in   alarm enable (level)
//   stop_alarm   in   clears sound_alarm
//   reset_count  out  restart request to the generator (copy of load_time)
//   cur_time     out  current time, same packing as new_time
//   alarm_time   out  stored alarm time, same packing
//   sound_alarm  out  alarm active (level)
//   load_err     out  one-cycle pulse when a load request is rejected
// ---------------------------------------------------------------------------
module aclk_time_counter (
   input  logic        clk,
   input  logic        reset,
   input  logic        one_minute,
   input  logic        load_time,
   input  logic        load_alarm,
   input  logic [15:0] new_time,
   input  logic        alarm_en,
   input  logic        stop_alarm,
   output logic        reset_count,
   output logic [15:0] cur_time,
   output logic [15:0] alarm_time,
   output logic        sound_alarm,
   output logic        load_err
);

   logic [15:0] cur_time_r;
   logic [15:0] alarm_time_r;
   logic        sound_alarm_r;
   logic        load_err_r;

   logic        new_valid_s;
   logic [15:0] next_time_s;
   logic        advance_s;
   logic        match_s;
   logic        clear_s;

   // Checks that a packed HH:MM value is a legal 24-hour BCD time.
   function automatic logic time_valid(input logic [15:0] t);
      logic [3:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
      logic       ok;
      h1 = t[15:12];
      h0 = t[11:8];
      m1 = t[7:4];
      m0 = t[3:0];
      ok = (h1 <= 4'd2) && (h0 <= 4'd9) && (m1 <= 4'd5) && (m0 <= 4'd9);
      if ((h1 == 4'd2) && (h0 > 4'd3)) begin
         ok = 1'b0;
      end else begin
         ok = ok;
      end
      return ok;
   endfunction

   // Adds one minute to a valid BCD HH:MM value, wrapping 23:59 to 00:00.
   function automatic logic [15:0] time_inc(input logic [15:0] t);
      logic [3:0] h1;
      logic [3:0] h0;
      logic [3:0] m1;
      logic [3:0] m0;
      h1 = t[15:12];
      h0 = t[11:8];
      m1 = t[7:4];
      m0 = t[3:0];
      if (m0 != 4'd9) begin
         m0 = m0 + 4'd1;
      end else begin
         m0 = 4'd0;
         if (m1 != 4'd5) begin
            m1 = m1 + 4'd1;
         end else begin
            m1 = 4'd0;
            if ((h1 == 4'd2) && (h0 == 4'd3)) begin
               h1 = 4'd0;
               h0 = 4'd0;
            end else if (h0 == 4'd9) begin
               h0 = 4'd0;
               h1 = h1 + 4'd1;
            end else begin
               h0 = h0 + 4'd1;
            end
         end
      end
      return {h1, h0, m1, m0};
   endfunction

   // Decodes the per-cycle controls: validity, the increment, the alarm match and the clear.
   always_comb begin
      new_valid_s = time_valid(new_time);
      next_time_s = time_inc(cur_time_r);
      // A load in the same cycle drops the strobe instead of deferring it.
      advance_s   = one_minute & ~load_time;
      match_s     = advance_s & alarm_en & (next_time_s == alarm_time_r);
      clear_s     = stop_alarm | ~alarm_en;
   end

   // Holds the time, alarm, alarm-active and load-error state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_time_r    <= 16'h0000;
         alarm_time_r  <= 16'h0000;
         sound_alarm_r <= 1'b0;
         load_err_r    <= 1'b0;
      end else begin
         if (load_time) begin
            if (new_valid_s) begin
               cur_time_r <= new_time;
            end else begin
               cur_time_r <= cur_time_r;
            end
         end else if (advance_s) begin
            cur_time_r <= next_time_s;
         end else begin
            cur_time_r <= cur_time_r;
         end

         if (load_alarm && new_valid_s) begin
            alarm_time_r <= new_time;
         end else begin
            alarm_time_r <= alarm_time_r;
         end

         // A simultaneous load of both registers still produces only one pulse.
         load_err_r <= (load_time | load_alarm) & ~new_valid_s;

         // When a clear and a set arrive in the same cycle, the clear wins.
         if (clear_s) begin
            sound_alarm_r <= 1'b0;
         end else if (match_s) begin
            sound_alarm_r <= 1'b1;
         end else begin
            sound_alarm_r <= sound_alarm_r;
         end
      end
   end

   // The generator must restart in the same cycle as the load, so this path stays combinational.
   assign reset_count = load_time;
   assign cur_time    = cur_time_r;
   assign alarm_time  = alarm_time_r;
   assign sound_alarm = sound_alarm_r;
   assign load_err    = load_err_r;

endmodule

// File: tb/tb_aclk_time_counter.sv
// ---------------------------------------------------------------------------
// tb_aclk_time_counter
//
// Directed testbench for aclk_time_counter. It applies a table of per-cycle
// input records with expected outputs worked out by hand. After the table it
// runs a hand-written sequence that resets the design while the alarm is on.
// ---------------------------------------------------------------------------
module tb_aclk_time_counter;

   logic        clk;
   logic        reset;
   logic        one_minute;
   logic        load_time;
   logic        load_alarm;
   logic [15:0] new_time;
   logic        alarm_en;
   logic        stop_alarm;
   logic        reset_count;
   logic [15:0] cur_time;
   logic [15:0] alarm_time;
   logic        sound_alarm;
   logic        load_err;

   int errors;
   int checks;

   typedef struct {
      logic        om;
      logic        lt;
      logic        la;
      logic        ae;
      logic        st;
      logic [15:0] nt;
      logic [15:0] e_cur;
      logic [15:0] e_alm;
      logic        e_snd;
      logic        e_err;
   } vec_t;

   vec_t vecs[$];

   aclk_time_counter dut (
      .clk         (clk),
      .reset       (reset),
      .one_minute  (one_minute),
      .load_time   (load_time),
      .load_alarm  (load_alarm),
      .new_time    (new_time),
      .alarm_en    (alarm_en),
      .stop_alarm  (stop_alarm),
      .reset_count (reset_count),
      .cur_time    (cur_time),
      .alarm_time  (alarm_time),
      .sound_alarm (sound_alarm),
      .load_err    (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(input logic om, input logic lt, input logic la,
                               input logic ae, input logic st, input logic [15:0] nt,
                               input logic [15:0] e_cur, input logic [15:0] e_alm,
                               input logic e_snd, input logic e_err);
      vec_t v;
      v.om = om; v.lt = lt; v.la = la; v.ae = ae; v.st = st; v.nt = nt;
      v.e_cur = e_cur; v.e_alm = e_alm; v.e_snd = e_snd; v.e_err = e_err;
      return v;
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_idle();
      one_minute = 1'b0;
      load_time  = 1'b0;
      load_alarm = 1'b0;
      stop_alarm = 1'b0;
      new_time   = 16'h0000;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      reset  = 1'b1;
      alarm_en = 1'b0;
      drive_idle();

      //        om    lt    la    ae    st    new_time  cur       alarm     snd   err
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0959, 16'h0959, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1000, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1959, 16'h1959, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h2000, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2359, 16'h2359, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      // rejected loads
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h2400, 16'h0000, 16'h0000, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1260, 16'h0000, 16'h0000, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0A00, 16'h0000, 16'h0000, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0));
      // alarm match and hold, then stop
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0705, 16'h0000, 16'h0705, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0704, 16'h0704, 16'h0705, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0705, 16'h0705, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0706, 16'h0705, 1'b1, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0707, 16'h0705, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0707, 16'h0705, 1'b0, 1'b0));
      // disabled alarm, load onto the alarm value, stop in the match cycle
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0704, 16'h0704, 16'h0705, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0705, 16'h0705, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0705, 16'h0705, 16'h0705, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0704, 16'h0704, 16'h0705, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0705, 16'h0705, 1'b0, 1'b0));
      // load beats strobe
      vecs.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1111, 16'h1111, 16'h0705, 1'b0, 1'b0));
      // alarm register loads: invalid, combined, combined invalid
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h2400, 16'h1111, 16'h0705, 1'b0, 1'b1));
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1230, 16'h1230, 16'h1230, 1'b0, 1'b0));
      vecs.push_back(mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h2360, 16'h1230, 16'h1230, 1'b0, 1'b1));
      // match, then re-program the alarm while sounding, then disable
      vecs.push_back(mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1229, 16'h1229, 16'h1230, 1'b0, 1'b0));
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h1230, 16'h1230, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0800, 16'h1230, 16'h0800, 1'b1, 1'b0));
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1230, 16'h0800, 1'b0, 1'b0));

      // reset state
      @(posedge clk);
      @(negedge clk);
      chk("reset_cur", cur_time, 16'h0000);
      chk("reset_alarm", alarm_time, 16'h0000);
      chk("reset_sound", {15'd0, sound_alarm}, 16'h0000);
      chk("reset_err", {15'd0, load_err}, 16'h0000);
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         one_minute = vecs[i].om;
         load_time  = vecs[i].lt;
         load_alarm = vecs[i].la;
         alarm_en   = vecs[i].ae;
         stop_alarm = vecs[i].st;
         new_time   = vecs[i].nt;
         #1;
         chk($sformatf("v%0d_reset_count", i), {15'd0, reset_count}, {15'd0, vecs[i].lt});
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_cur", i), cur_time, vecs[i].e_cur);
         chk($sformatf("v%0d_alarm", i), alarm_time, vecs[i].e_alm);
         chk($sformatf("v%0d_sound", i), {15'd0, sound_alarm}, {15'd0, vecs[i].e_snd});
         chk($sformatf("v%0d_err", i), {15'd0, load_err}, {15'd0, vecs[i].e_err});
      end

      // Hand sequence: sound the alarm, then reset between edges with a strobe pending.
      @(negedge clk);
      drive_idle();
      alarm_en   = 1'b1;
      load_time  = 1'b1;
      new_time   = 16'h0759;
      @(negedge clk);
      drive_idle();
      one_minute = 1'b1;
      @(posedge clk);
      #1;
      chk("seq_cur_0800", cur_time, 16'h0800);
      chk("seq_sound_on", {15'd0, sound_alarm}, 16'h0001);
      @(negedge clk);
      one_minute = 1'b1;
      load_alarm = 1'b1;
      new_time   = 16'h2400;
      #2;
      reset = 1'b1;
      #1;
      chk("async_cur", cur_time, 16'h0000);
      chk("async_alarm", alarm_time, 16'h0000);
      chk("async_sound", {15'd0, sound_alarm}, 16'h0000);
      chk("async_err", {15'd0, load_err}, 16'h0000);
      @(negedge clk);
      drive_idle();
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("post_reset_cur", cur_time, 16'h0000);
      chk("post_reset_sound", {15'd0, sound_alarm}, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
